// File: rtl/piso8_pkg.sv
// Shared state codes and constants for the piso8 parallel-to-serial converter.
package piso8_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  localparam logic [2:0] PISO_LAST = 3'd7;

endpackage

// File: rtl/cnt3.sv
// 3-bit counter with async active-high reset, synchronous clear and increment.
module cnt3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= q + 3'd1;
  end

endmodule

// File: rtl/mux8.sv
// 8:1 single-bit select.
module mux8 (
  input  logic [7:0] ins,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = ins[sel];

endmodule

// File: rtl/piso8.sv
// Parallel-in serial-out converter: one 8-bit word per valid/ready load,
// emitted LSB first, one bit per accepted serial cycle.
module piso8
  import piso8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] data,
  input  logic       ser_ready,
  output logic       ser_valid,
  output logic       ser_out,
  output logic       last
);

  piso_state_e state;
  logic [7:0]  hold;
  logic [2:0]  cnt;
  logic        at_last;
  logic        load;
  logic        adv;
  logic        cnt_clr;
  logic        cnt_en;
  logic        mux_bit;

  assign at_last    = (cnt == PISO_LAST);
  assign ser_valid  = (state == PISO_SHIFT);
  assign load_ready = (state == PISO_IDLE) || (ser_valid && at_last && ser_ready);
  assign load       = load_valid && load_ready;
  assign adv        = ser_valid && ser_ready;
  // The index clears both on a new word and on retiring bit 7; clr wins over en.
  assign cnt_clr    = load || (adv && at_last);
  assign cnt_en     = adv && !at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PISO_IDLE;
      hold  <= '0;
    end else if (load) begin
      state <= PISO_SHIFT;
      hold  <= data;
    end else if (adv && at_last) begin
      state <= PISO_IDLE;
    end
  end

  cnt3 u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .q   (cnt)
  );

  mux8 u_mux (
    .ins (hold),
    .sel (cnt),
    .y   (mux_bit)
  );

  assign ser_out = mux_bit & ser_valid;
  assign last    = ser_valid && at_last;

endmodule
